// File: rtl/minterm_equiv_checker_pkg.sv
// minterm_equiv_pkg: shared state encoding and sweep timing helpers for the minterm equivalence checker
package minterm_equiv_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, CMP, DONE} state_e;

    function automatic int sweep_len(input int n);
        return 1 << n;
    endfunction

    // Edge index (start edge = 0) after which done is high for one cycle
    function automatic int done_latency(input int n, input int settle);
        return 1 + sweep_len(n) * (settle + 1);
    endfunction

endpackage

// File: rtl/minterm_equiv_checker_if.sv
// minterm_equiv_checker_if: sweep control, stimulus and result bus between the checker and its environment
interface minterm_equiv_checker_if #(parameter int N_VARS = 4);
    logic              start;
    logic              s_normal;
    logic              s_reduced;
    logic [N_VARS-1:0] minterm;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_VARS:0]   mismatch_cnt;
    logic [N_VARS-1:0] first_bad;
    logic              first_bad_valid;

    modport master (
        input  start, s_normal, s_reduced,
        output minterm, busy, done, pass, mismatch_cnt, first_bad, first_bad_valid
    );

    modport slave (
        output start, s_normal, s_reduced,
        input  minterm, busy, done, pass, mismatch_cnt, first_bad, first_bad_valid
    );
endinterface

// File: rtl/minterm_equiv_checker_mismatch_tracker.sv
// mismatch_tracker: counts mismatching minterms and latches the lowest one seen in a sweep
module mismatch_tracker #(
    parameter int N_VARS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              sample_en,
    input  logic              mismatch,
    input  logic [N_VARS-1:0] minterm,
    output logic [N_VARS:0]   mismatch_cnt,
    output logic [N_VARS-1:0] first_bad,
    output logic              first_bad_valid
);
    logic [N_VARS:0]   cnt_q, cnt_d;
    logic [N_VARS-1:0] fb_q, fb_d;
    logic              fbv_q, fbv_d, hit;

    always_comb begin
        hit   = sample_en && mismatch;
        cnt_d = clear ? '0 : cnt_q + (N_VARS+1)'(hit);
        fb_d  = clear ? '0 : (hit && !fbv_q) ? minterm : fb_q;
        fbv_d = clear ? 1'b0 : fbv_q | hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            fb_q  <= '0;
            fbv_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            fb_q  <= fb_d;
            fbv_q <= fbv_d;
        end
    end

    assign mismatch_cnt    = cnt_q;
    assign first_bad       = fb_q;
    assign first_bad_valid = fbv_q;
endmodule

// File: rtl/minterm_equiv_checker.sv
// minterm_equiv_checker: sweeps every minterm, compares two boolean functions and reports pass/fail
module minterm_equiv_checker
    import minterm_equiv_pkg::*;
#(
    parameter int N_VARS = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    minterm_equiv_checker_if.master bus
);
    localparam int WW = SETTLE > 1 ? $clog2(SETTLE + 1) : 1;
    localparam logic [WW-1:0] SETTLE_W = WW'(SETTLE);
    localparam state_e AFTER = SETTLE == 0 ? CMP : WAIT;

    state_e            state_q, state_d;
    logic [N_VARS-1:0] minterm_q, minterm_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic              accept, last;
    logic [N_VARS:0]   cnt;

    assign accept = state_q == IDLE && bus.start;
    // Last minterm is detected explicitly so the counter never wraps
    assign last   = minterm_q == N_VARS'(sweep_len(N_VARS) - 1);

    always_comb begin
        state_d   = state_q;
        minterm_d = minterm_q;
        wait_d    = wait_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d   = AFTER;
                minterm_d = '0;
                wait_d    = SETTLE_W;
                busy_d    = 1'b1;
                pass_d    = 1'b0;
            end
            WAIT: begin
                wait_d  = wait_q - WW'(1);
                state_d = wait_q == WW'(1) ? CMP : WAIT;
            end
            CMP: if (last) begin
                state_d = DONE;
            end else begin
                minterm_d = minterm_q + N_VARS'(1);
                wait_d    = SETTLE_W;
                state_d   = AFTER;
            end
            DONE: begin
                state_d   = IDLE;
                minterm_d = '0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                pass_d    = cnt == '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            minterm_q <= '0;
            wait_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            minterm_q <= minterm_d;
            wait_q    <= wait_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    mismatch_tracker #(.N_VARS(N_VARS)) u_tracker (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (accept),
        .sample_en       (state_q == CMP),
        .mismatch        (bus.s_normal ^ bus.s_reduced),
        .minterm         (minterm_q),
        .mismatch_cnt    (cnt),
        .first_bad       (bus.first_bad),
        .first_bad_valid (bus.first_bad_valid)
    );

    assign bus.minterm      = minterm_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = cnt;
endmodule

// File: tb/tb_minterm_equiv_checker.sv
// tb_minterm_equiv_checker: table-driven sweeps over three checker configurations with a result scoreboard
module tb_minterm_equiv_checker;
    import minterm_equiv_pkg::*;

    typedef struct {
        logic [4:0] cnt;
        logic [3:0] first;
        logic       valid;
        logic       pass;
    } exp_t;

    typedef struct {
        int          sel;
        logic [15:0] mask;
        exp_t        e;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    int          sel = 0;
    logic [15:0] mask = '0;
    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    minterm_equiv_checker_if #(.N_VARS(4)) b4 ();
    minterm_equiv_checker_if #(.N_VARS(4)) b0 ();
    minterm_equiv_checker_if #(.N_VARS(3)) b3 ();

    minterm_equiv_checker #(.N_VARS(4), .SETTLE(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    minterm_equiv_checker #(.N_VARS(4), .SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    minterm_equiv_checker #(.N_VARS(3), .SETTLE(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    // Reduced output = original output flipped wherever mask has a 1
    assign b4.start     = start && sel == 0;
    assign b0.start     = start && sel == 1;
    assign b3.start     = start && sel == 2;
    assign b4.s_normal  = (b4.minterm[3] & (~b4.minterm[1] | ~b4.minterm[2])) ^ b4.minterm[0];
    assign b0.s_normal  = (b0.minterm[3] & (~b0.minterm[1] | ~b0.minterm[2])) ^ b0.minterm[0];
    assign b3.s_normal  = b3.minterm[2] & (~b3.minterm[0] | ~b3.minterm[1]);
    assign b4.s_reduced = b4.s_normal ^ mask[b4.minterm];
    assign b0.s_reduced = b0.s_normal ^ mask[b0.minterm];
    assign b3.s_reduced = b3.s_normal ^ mask[b3.minterm];

    logic [4:0] cnt_m;
    logic [3:0] mt_m, fb_m;
    logic       busy_m, done_m, pass_m, fbv_m;

    always_comb begin
        mt_m   = sel == 2 ? {1'b0, b3.minterm} : sel == 1 ? b0.minterm : b4.minterm;
        cnt_m  = sel == 2 ? {1'b0, b3.mismatch_cnt} : sel == 1 ? b0.mismatch_cnt : b4.mismatch_cnt;
        fb_m   = sel == 2 ? {1'b0, b3.first_bad} : sel == 1 ? b0.first_bad : b4.first_bad;
        busy_m = sel == 2 ? b3.busy : sel == 1 ? b0.busy : b4.busy;
        done_m = sel == 2 ? b3.done : sel == 1 ? b0.done : b4.done;
        pass_m = sel == 2 ? b3.pass : sel == 1 ? b0.pass : b4.pass;
        fbv_m  = sel == 2 ? b3.first_bad_valid : sel == 1 ? b0.first_bad_valid : b4.first_bad_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int s, input logic [15:0] m, input int c, input int f,
                                input logic v, input logic p, input string n);
        vec_t r;
        r.sel     = s;
        r.mask    = m;
        r.e.cnt   = 5'(c);
        r.e.first = 4'(f);
        r.e.valid = v;
        r.e.pass  = p;
        r.name    = n;
        return r;
    endfunction

    task automatic run(input vec_t v, input int restart_at);
        int   cyc, lat, prev, seen;
        logic pulsed;
        exp_t e;
        lat = done_latency(v.sel == 2 ? 3 : 4, v.sel == 1 ? 0 : 1);
        @(negedge clk);
        sel   = v.sel;
        mask  = v.mask;
        start = 1'b1;
        sb.push_back(v.e);
        @(negedge clk);
        start = 1'b0;
        chk({v.name, "_busy"}, 32'(busy_m), 1);
        cyc    = 0;
        seen   = 0;
        pulsed = 1'b0;
        prev   = int'(mt_m);
        while (!done_m && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (pulsed && seen < 2 && int'(mt_m) != prev) begin
                chk({v.name, "_mt_step"}, 32'(mt_m), 32'(prev + 1));
                seen++;
            end
            if (restart_at >= 0 && !pulsed && int'(mt_m) == restart_at) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            prev = int'(mt_m);
        end
        chk({v.name, "_latency"}, 32'(cyc), 32'(lat));
        chk({v.name, "_sb_depth"}, 32'(sb.size()), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({v.name, "_cnt"}, 32'(cnt_m), 32'(e.cnt));
            chk({v.name, "_first_bad"}, 32'(fb_m), 32'(e.first));
            chk({v.name, "_first_valid"}, 32'(fbv_m), 32'(e.valid));
            chk({v.name, "_pass"}, 32'(pass_m), 32'(e.pass));
        end
        chk({v.name, "_busy_at_done"}, 32'(busy_m), 0);
        @(negedge clk);
        chk({v.name, "_done_width"}, 32'(done_m), 0);
    endtask

    initial begin
        vec_t tbl[10];
        int   cyc;
        logic saw_done;
        tbl[0] = mk(2, 16'h0000, 0,  0,  1'b0, 1'b1, "n3_equal");
        tbl[1] = mk(2, 16'h0008, 1,  3,  1'b1, 1'b0, "n3_m3");
        tbl[2] = mk(0, 16'h0000, 0,  0,  1'b0, 1'b1, "n4_equal");
        tbl[3] = mk(0, 16'h0040, 1,  6,  1'b1, 1'b0, "n4_m6");
        tbl[4] = mk(0, 16'hFFFF, 16, 0,  1'b1, 1'b0, "n4_inverted");
        tbl[5] = mk(0, 16'h8000, 1,  15, 1'b1, 1'b0, "n4_last");
        tbl[6] = mk(0, 16'hA5A0, 6,  5,  1'b1, 1'b0, "n4_scatter");
        tbl[7] = mk(1, 16'h0000, 0,  0,  1'b0, 1'b1, "s0_equal");
        tbl[8] = mk(1, 16'h0300, 2,  8,  1'b1, 1'b0, "s0_m8_m9");
        tbl[9] = mk(1, 16'hFFFF, 16, 0,  1'b1, 1'b0, "s0_inverted");

        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset_state_%0d", s),
                32'({mt_m, busy_m, done_m, pass_m, cnt_m, fb_m, fbv_m}), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run(tbl[i], -1);
        run(mk(0, 16'h0040, 1, 6, 1'b1, 1'b0, "restart_ignored"), 5);

        // Abort a sweep with reset once it has already recorded a mismatch
        @(negedge clk);
        sel   = 0;
        mask  = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (mt_m != 4'd5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_m5", 32'(mt_m), 5);
        chk("abort_pre_valid", 32'(fbv_m), 1);
        #2 rst_n = 1'b0;
        #1 chk("abort_cleared", 32'({mt_m, busy_m, done_m, pass_m, cnt_m, fb_m, fbv_m}), 0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_done = saw_done | done_m;
        end
        chk("abort_no_done", 32'(saw_done), 0);
        rst_n = 1'b1;
        run(mk(0, 16'h0040, 1, 6, 1'b1, 1'b0, "after_abort"), -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/minterm_equiv_checker.md
Name: minterm_equiv_checker

Overview:
Sequential truth-table sweeper and equivalence checker for the team's boolean-reduction exercises.
- Drives every minterm 0 .. 2^N_VARS-1 onto an external pair of combinational functions, the original expression and its reduced form.
- Samples both outputs for each minterm, counts mismatches, records the first failing minterm and reports pass/fail.
- It is the checking end of the stimulus/compare flow: the functions under test are the responders, this block is the initiator and scoreboard.

Parameters:
- N_VARS, 4, number of input variables; minterm bus width; sweep length 2^N_VARS.
- SETTLE, 1, wait cycles after driving a minterm before sampling. 0 is allowed.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; accepted only in IDLE.
- minterm  out  N_VARS  current input vector to the functions under test; MSB = first variable (x).
- s_normal  in  1  output of the original expression.
- s_reduced  in  1  output of the reduced expression.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of a sweep.
- pass  out  1  1 when the last sweep had zero mismatches; held until the next start.
- mismatch_cnt  out  N_VARS+1  number of mismatching minterms in the last sweep; range 0..2^N_VARS.
- first_bad  out  N_VARS  lowest mismatching minterm; valid only when first_bad_valid is high.
- first_bad_valid  out  1  at least one mismatch recorded.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; minterm=0; busy=0; done=0; pass=0; mismatch_cnt=0; first_bad=0; first_bad_valid=0; wait counter=0.
- Reset asserted mid-sweep aborts the sweep immediately. No done pulse is produced, and the partial results are discarded.
- States: IDLE, WAIT, CMP, DONE.
- IDLE, start=1: clear mismatch_cnt, first_bad, first_bad_valid and pass; set minterm=0 and busy=1. Next state is WAIT with wait counter = SETTLE, or CMP if SETTLE=0.
- WAIT: decrement the wait counter; go to CMP when it reaches 1. minterm is stable throughout.
- CMP: sample s_normal and s_reduced in this cycle.
  - If they differ: mismatch_cnt += 1. If first_bad_valid=0, latch first_bad=minterm and set first_bad_valid=1.
  - If minterm = 2^N_VARS-1: go to DONE. Otherwise minterm += 1 and go to WAIT (or stay in CMP when SETTLE=0).
- DONE: done=1 for exactly one cycle; busy=0; pass=(mismatch_cnt==0), using the count that includes the final CMP; minterm returns to 0; next state is IDLE.
- Timing: each minterm occupies SETTLE+1 cycles. If start is sampled at edge 0, done is high in the cycle following edge 1 + 2^N_VARS*(SETTLE+1).
- start while busy or in DONE: ignored, with no effect on the sweep in progress.
- mismatch_cnt width N_VARS+1 holds the full count 2^N_VARS without wrap. The minterm counter never wraps; the last minterm is detected explicitly.
- Comparison is a plain XOR of the two inputs. Inputs are treated as synchronous to clk, with combinational paths allowed to settle within SETTLE cycles.

Decomposition:
- Package minterm_equiv_pkg holds:
  - the state enum (IDLE, WAIT, CMP, DONE);
  - a localparam function giving the sweep length 2^N;
  - a helper computing the done latency from N and SETTLE, for the bench.
- One sub-module, mismatch_tracker, holds mismatch_cnt, first_bad and first_bad_valid. Its interface: clear, sample_en, mismatch, minterm. The FSM and minterm counter stay in the top module.

Test Plan:
- N_VARS=3, SETTLE=1. Both inputs driven by x&(~z|~y) of minterm, start pulse -> done at the predicted edge, pass=1, mismatch_cnt=0, first_bad_valid=0.
- N_VARS=4. s_reduced equals s_normal except inverted at minterm 6 -> mismatch_cnt=1, first_bad=6, first_bad_valid=1, pass=0.
- N_VARS=4. s_reduced = ~s_normal -> mismatch_cnt=16 (no wrap), first_bad=0, pass=0.
- N_VARS=4, SETTLE=0. Start sampled at edge 0 -> minterm advances every cycle; done high in the cycle after edge 17, only one cycle long.
- Start pulsed again mid-sweep at minterm 5 -> ignored; minterm continues 6, 7, and the final results match a clean sweep.
- rst_n dropped asynchronously while minterm=5 -> all outputs return to reset values immediately and no done pulse. A fresh start afterwards completes a normal sweep.
